kmu_unpacker: RTL and testbench
===============================

Name: kmu_unpacker

Overview:
- Streaming inverse of the ZBKB pack/zip path in the KMU.
- Accepts one WIDTH-bit packed word per handshake and emits it as two WIDTH/2-bit halves on an output handshake, lower half first.
- Per word, it can optionally unzip (gather even/odd bits) or brev8 (reverse bits within each byte) before splitting.
- Sits between the KMU result path and downstream halfword consumers, for example key-schedule or S-box feeders.

Parameters:
- WIDTH, 32: packed input width. Must be a multiple of 16; 32 and 64 are supported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- InValid  input  1  input word valid.
- InReady  output  1  unit can accept a word this cycle.
- InData  input  WIDTH  packed word.
- InMode  input  2  transform: 00 = plain split, 01 = unzip split, 10 = brev8 then split, 11 = treated as 00.
- OutValid  output  1  output halfword valid.
- OutReady  input  1  consumer accepts the halfword.
- OutData  output  WIDTH/2  halfword.
- OutLast  output  1  asserted with the upper (second) half.
- Busy  output  1  a word is held (state is not IDLE).

Behaviour:
- Reset: the asynchronous assertion of reset_n low forces the following, independent of clk:
  - state = IDLE
  - OutValid = 0, OutLast = 0, Busy = 0, OutData = 0
  - holding register cleared
- InReady after reset: InReady = 1 once reset_n deasserts.
- Input acceptance:
  - Input handshake occurs when InValid & InReady are both high at a clock edge.
  - The transformed word T is registered into Hold at that edge.
- Transform T:
  - mode 00: T = InData.
  - mode 10: T[8i+j] = InData[8i+7-j].
  - mode 01: T[k] = InData[2k] and T[WIDTH/2+k] = InData[2k+1], for k = 0..WIDTH/2-1.
- Output handshake: occurs when OutValid & OutReady are both high.
- States: IDLE, EMIT_LO, EMIT_HI.
  - IDLE: InReady = 1, OutValid = 0. An input handshake moves to EMIT_LO.
  - EMIT_LO:
    - OutValid = 1, OutData = Hold[WIDTH/2-1:0], OutLast = 0, InReady = 0.
    - An output handshake moves to EMIT_HI.
  - EMIT_HI:
    - OutValid = 1, OutData = Hold[WIDTH-1:WIDTH/2], OutLast = 1.
    - InReady = OutReady (combinational; this is the only combinational in-to-out path).
    - An output handshake with an input handshake in the same cycle moves to EMIT_LO, with Hold loaded from the new word.
    - An output handshake without an input handshake moves to IDLE.
- Latency: the first half is visible the cycle after input acceptance. Throughput is one word per 2 cycles with no bubbles under continuous OutReady.
- Data outputs:
  - OutData and OutLast are driven from registered Hold and state only, never from InData.
  - OutData is held stable while OutValid & !OutReady (AXI-style; no retraction).
- Input sampling:
  - InData/InMode are sampled only on input handshake.
  - Changes while InReady = 0 are ignored.
- Reset mid-operation: the held word is discarded and never emitted; the next word after reset starts at EMIT_LO.
- Busy = (state != IDLE).

Optional Feature:
- KMU_UNPACK_PARITY_EN defined:
  - Adds output OutParity (1 bit) = XOR-reduction of OutData, registered alongside Hold as two precomputed bits (lo/hi).
  - OutParity resets to 0.
  - OutParity is valid whenever OutValid = 1.
- Undefined: the OutParity port and its registers are absent; all other behaviour is identical.

Decomposition:
- Package kmu_unpack_pkg:
  - typedef enum logic [1:0] unpack_mode_t: PLAIN, UNZIP, BREV8, RSVD.
  - typedef enum logic [1:0] unpack_state_t: IDLE, EMIT_LO, EMIT_HI.
- Sub-module unzip_gather #(WIDTH):
  - Purely combinational even/odd bit gather producing T for mode 01.
  - Reusable and unit-testable alone.
- The brev8 and plain paths are wiring inside kmu_unpacker.

Test Plan (WIDTH = 32):
- Plain split: InData = 0xAAAA5555, mode 00, OutReady = 1 -> cycle+1 OutData = 0x5555, OutLast = 0; cycle+2 OutData = 0xAAAA, OutLast = 1; then IDLE, Busy = 0.
- Unzip: InData = 0xAAAAAAAA, mode 01 -> 0x0000 then 0xFFFF. InData = 0x00000003, mode 01 -> 0x0001 then 0x0001.
- Brev8: InData = 0x01020380, mode 10 -> 0xC001 then 0x8040. Mode 11 with the same data -> 0x0380 then 0x0102.
- Backpressure:
  - Stimulus: OutReady low for 3 cycles in EMIT_LO and for 2 cycles in EMIT_HI; InData toggles every cycle.
  - Required: OutData stable throughout; InReady = 0 in EMIT_LO; no word accepted until the HI handshake.
- Throughput: 4 consecutive words with InValid and OutReady held high -> 8 halfwords in 8 consecutive cycles; InReady pulses high only in EMIT_HI; order lo0, hi0, lo1, ...
- Reset mid-op: reset_n driven low asynchronously between edges while in EMIT_HI -> OutValid drops immediately. After release, InReady = 1 and the old word is never emitted. With KMU_UNPACK_PARITY_EN, the 0x0001/0x0003 halves give OutParity 1/0.

Source files
------------

// File: rtl/kmu_unpack_pkg.sv
// Shared types for the KMU unpack path.
// Transform selector encoding and the unpacker's state encoding.
// Imported by kmu_unpacker.
package kmu_unpack_pkg;

    typedef enum logic [1:0] {
        PLAIN = 2'b00,
        UNZIP = 2'b01,
        BREV8 = 2'b10,
        RSVD  = 2'b11
    } unpack_mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        EMIT_LO = 2'b01,
        EMIT_HI = 2'b10
    } unpack_state_t;

endpackage

// File: rtl/unzip_gather.sv
// Purpose: even/odd bit gather (inverse of zip); even bits to the low half, odd bits to the high half.
// Latency: purely combinational.
// Backpressure: none, no handshake.
// Ports: din  - WIDTH-bit packed word
//        dout - dout[k] = din[2k], dout[WIDTH/2+k] = din[2k+1]
module unzip_gather #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    for (genvar k = 0; k < WIDTH / 2; k++) begin : g_gather
        assign dout[k]           = din[2 * k];
        assign dout[WIDTH/2 + k] = din[2 * k + 1];
    end

endmodule

// File: rtl/kmu_unpacker.sv
// Purpose: accepts one packed word, optionally unzips or brev8s it, emits it as two halfwords (lower first).
// Latency: low half valid the cycle after input acceptance; one word per 2 cycles with OutReady held high.
// Backpressure: OutData held stable while OutReady is low; InReady = 0 in EMIT_LO, InReady = OutReady in EMIT_HI.
// Ports: clk, reset_n (async active-low); InValid/InReady/InData/InMode input handshake;
//        OutValid/OutReady/OutData/OutLast output handshake (OutLast marks the upper half); Busy = a word is held.
// Option: define KMU_UNPACK_PARITY_EN to add OutParity, the XOR-reduction of OutData.
module kmu_unpacker
    import kmu_unpack_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               InValid,
    output logic               InReady,
    input  logic [WIDTH-1:0]   InData,
    input  logic [1:0]         InMode,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [WIDTH/2-1:0] OutData,
    output logic               OutLast,
    output logic               Busy
`ifdef KMU_UNPACK_PARITY_EN
    ,
    output logic               OutParity
`endif
);

    localparam int HALF = WIDTH / 2;

    unpack_state_t    state;
    unpack_state_t    state_nxt;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] xform;
    logic [WIDTH-1:0] unzip_w;
    logic [WIDTH-1:0] brev_w;
    logic             in_hs;
    logic             out_hs;

    // ---------------------------------------------------------------
    // Transform paths, all computed from the live input word
    // ---------------------------------------------------------------
    unzip_gather #(
        .WIDTH (WIDTH)
    ) u_unzip (
        .din  (InData),
        .dout (unzip_w)
    );

    for (genvar b = 0; b < WIDTH / 8; b++) begin : g_byte
        for (genvar j = 0; j < 8; j++) begin : g_bit
            assign brev_w[8 * b + j] = InData[8 * b + 7 - j];
        end
    end

    // The reserved encoding falls through to the plain split.
    always_comb begin
        xform = InData;
        case (unpack_mode_t'(InMode))
            UNZIP:   xform = unzip_w;
            BREV8:   xform = brev_w;
            default: xform = InData;
        endcase
    end

    assign in_hs  = InValid & InReady;
    assign out_hs = OutValid & OutReady;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_hs) state_nxt = EMIT_LO;
            end
            EMIT_LO: begin
                if (out_hs) state_nxt = EMIT_HI;
            end
            EMIT_HI: begin
                // A new word can land in the same cycle the upper half leaves.
                if (out_hs) state_nxt = in_hs ? EMIT_LO : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs (data taken from the holding register only)
    // ---------------------------------------------------------------
    always_comb begin
        InReady  = 1'b0;
        OutValid = 1'b0;
        OutLast  = 1'b0;
        OutData  = hold[HALF-1:0];
        case (state)
            IDLE: begin
                InReady = 1'b1;
            end
            EMIT_LO: begin
                OutValid = 1'b1;
            end
            EMIT_HI: begin
                OutValid = 1'b1;
                OutLast  = 1'b1;
                OutData  = hold[WIDTH-1:HALF];
                InReady  = OutReady;
            end
            default: InReady = 1'b0;
        endcase
    end

    assign Busy = (state != IDLE);

    // ---------------------------------------------------------------
    // Holding register, loaded only on an input handshake
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold <= '0;
        end else if (in_hs) begin
            hold <= xform;
        end
    end

`ifdef KMU_UNPACK_PARITY_EN
    logic par_lo;
    logic par_hi;

    // Both half parities precomputed at load so OutParity is a mux, not an XOR tree.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_lo <= 1'b0;
            par_hi <= 1'b0;
        end else if (in_hs) begin
            par_lo <= ^xform[HALF-1:0];
            par_hi <= ^xform[WIDTH-1:HALF];
        end
    end

    assign OutParity = (state == EMIT_HI) ? par_hi : par_lo;
`endif

endmodule

// File: tb/tb_kmu_unpacker.sv
module tb_kmu_unpacker;

    localparam int W = 32;
    localparam int H = W / 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         InValid;
    logic         InReady;
    logic [W-1:0] InData;
    logic [1:0]   InMode;
    logic         OutValid;
    logic         OutReady;
    logic [H-1:0] OutData;
    logic         OutLast;
    logic         Busy;
`ifdef KMU_UNPACK_PARITY_EN
    logic         OutParity;
`endif

    always #5 clk = ~clk;

    kmu_unpacker #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .InValid  (InValid),
        .InReady  (InReady),
        .InData   (InData),
        .InMode   (InMode),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData),
        .OutLast  (OutLast),
        .Busy     (Busy)
`ifdef KMU_UNPACK_PARITY_EN
        ,
        .OutParity(OutParity)
`endif
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int acc_cnt   = 0;
    int out_cnt   = 0;

    // Model: halfwords still owed to the consumer, in emission order.
    logic [H-1:0] mq[$];
    // Hand-computed halfwords for every word the stimulus offers.
    logic [H-1:0] lq[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Scatter form of the transform: each input bit is sent to its destination.
    function automatic logic [W-1:0] model_xform(input logic [W-1:0] d, input logic [1:0] m);
        logic [W-1:0] t;
        int           dst;
        t = '0;
        for (int i = 0; i < W; i++) begin
            if (m == 2'b01)      dst = (i % 2 == 0) ? (i / 2) : (H + i / 2);
            else if (m == 2'b10) dst = (i / 8) * 8 + 7 - (i % 8);
            else                 dst = i;
            t[dst] = d[i];
        end
        return t;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        logic         in_rdy;
        logic [W-1:0] t;
        if (!reset_n) begin
            mq.delete();
            lq.delete();
        end else begin
            in_rdy = (mq.size() == 0) || (mq.size() == 1 && OutReady);
            if (mq.size() > 0 && OutReady) begin
                void'(mq.pop_front());
                if (lq.size() > 0) void'(lq.pop_front());
                out_cnt++;
            end
            if (InValid && in_rdy) begin
                t = model_xform(InData, InMode);
                mq.push_back(t[H-1:0]);
                mq.push_back(t[W-1:H]);
                acc_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("out_valid", {31'd0, OutValid}, {31'd0, mq.size() > 0});
            chk("in_ready", {31'd0, InReady},
                {31'd0, (mq.size() == 0) || (mq.size() == 1 && OutReady)});
            chk("busy", {31'd0, Busy}, {31'd0, mq.size() > 0});
            if (mq.size() > 0) begin
                chk("out_data", {16'd0, OutData}, {16'd0, mq[0]});
                chk("out_last", {31'd0, OutLast}, {31'd0, mq.size() == 1});
`ifdef KMU_UNPACK_PARITY_EN
                chk("out_parity", {31'd0, OutParity}, {31'd0, ^mq[0]});
`endif
                if (lq.size() > 0) begin
                    chk("lit_data", {16'd0, OutData}, {16'd0, lq[0]});
                end else begin
                    total_cnt++;
                    $display("FAIL lit_data: got %h expected no output at %0t", OutData, $time);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [1:0] m,
                        input logic [H-1:0] lo, input logic [H-1:0] hi);
        int start;
        int n;
        start   = acc_cnt;
        n       = 0;
        InValid = 1'b1;
        InData  = d;
        InMode  = m;
        lq.push_back(lo);
        lq.push_back(hi);
        while (acc_cnt == start && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept", acc_cnt - start, 1);
    endtask

    task automatic idle(input int n);
        InValid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1);
    end

    initial begin
        int oc0;
        int ac0;
        reset_n  = 1'b1;
        InValid  = 1'b0;
        InData   = '0;
        InMode   = 2'b00;
        OutReady = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_out_valid", {31'd0, OutValid}, 0);
        chk("rst_out_last",  {31'd0, OutLast}, 0);
        chk("rst_busy",      {31'd0, Busy}, 0);
        chk("rst_out_data",  {16'd0, OutData}, 0);
`ifdef KMU_UNPACK_PARITY_EN
        chk("rst_parity",    {31'd0, OutParity}, 0);
`endif
        @(posedge clk);
        #1 reset_n = 1'b1;
        chk("in_ready_after_reset", {31'd0, InReady}, 1);

        // Plain split with explicit latency
        OutReady = 1'b1;
        send(32'hAAAA5555, 2'b00, 16'h5555, 16'hAAAA);
        InValid = 1'b0;
        chk("plain_lo", {16'd0, OutData}, 32'h5555);
        chk("plain_lo_last", {31'd0, OutLast}, 0);
        @(posedge clk); #1;
        chk("plain_hi", {16'd0, OutData}, 32'hAAAA);
        chk("plain_hi_last", {31'd0, OutLast}, 1);
        @(posedge clk); #1;
        chk("plain_done_busy", {31'd0, Busy}, 0);
        chk("plain_done_valid", {31'd0, OutValid}, 0);

        // Unzip, brev8, reserved mode
        send(32'hAAAAAAAA, 2'b01, 16'h0000, 16'hFFFF); idle(3);
        send(32'h00000003, 2'b01, 16'h0001, 16'h0001); idle(3);
        send(32'h01020380, 2'b10, 16'hC001, 16'h8040); idle(3);
        send(32'h01020380, 2'b11, 16'h0380, 16'h0102); idle(3);

        // Backpressure: 3 stalled cycles in EMIT_LO, 2 in EMIT_HI, input toggling
        OutReady = 1'b0;
        send(32'h12345678, 2'b00, 16'h5678, 16'h1234);
        ac0 = acc_cnt;
        for (int i = 0; i < 3; i++) begin
            InData = ~InData;
            InMode = ~InMode;
            @(posedge clk); #1;
            chk("bp_lo_stable", {16'd0, OutData}, 32'h5678);
            chk("bp_lo_in_ready", {31'd0, InReady}, 0);
        end
        OutReady = 1'b1;
        @(posedge clk); #1;
        OutReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            InData = ~InData;
            @(posedge clk); #1;
            chk("bp_hi_stable", {16'd0, OutData}, 32'h1234);
            chk("bp_hi_last", {31'd0, OutLast}, 1);
        end
        chk("bp_no_accept", acc_cnt - ac0, 0);
        InValid  = 1'b0;
        InMode   = 2'b00;
        OutReady = 1'b1;
        @(posedge clk); #1;
        chk("bp_no_accept_after", acc_cnt - ac0, 0);
        idle(2);

        // Throughput: four back-to-back words
        OutReady = 1'b1;
        send(32'h11110000, 2'b00, 16'h0000, 16'h1111);
        oc0 = out_cnt;
        send(32'h33332222, 2'b00, 16'h2222, 16'h3333);
        send(32'h55554444, 2'b00, 16'h4444, 16'h5555);
        send(32'h77776666, 2'b00, 16'h6666, 16'h7777);
        idle(2);
        chk("throughput_8_in_8", out_cnt - oc0, 8);
        idle(2);

        // Reset while holding the upper half
        OutReady = 1'b1;
        send(32'h00030001, 2'b00, 16'h0001, 16'h0003);
        InValid = 1'b0;
`ifdef KMU_UNPACK_PARITY_EN
        chk("parity_lo_lit", {31'd0, OutParity}, 1);
`endif
        @(posedge clk); #1;
        OutReady = 1'b0;
        chk("pre_rst_hi", {16'd0, OutData}, 32'h0003);
`ifdef KMU_UNPACK_PARITY_EN
        chk("parity_hi_lit", {31'd0, OutParity}, 0);
`endif
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, OutValid}, 0);
        chk("midrst_out_last",  {31'd0, OutLast}, 0);
        chk("midrst_busy",      {31'd0, Busy}, 0);
        chk("midrst_out_data",  {16'd0, OutData}, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        chk("in_ready_after_midrst", {31'd0, InReady}, 1);
        OutReady = 1'b1;
        idle(3);
        send(32'hBEEFCAFE, 2'b00, 16'hCAFE, 16'hBEEF);
        InValid = 1'b0;
        chk("post_rst_lo", {16'd0, OutData}, 32'hCAFE);
        idle(3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
